// File: rtl/grid_piece_writer.sv
// Grid RAM write agent: CHECK / PLACE / ERASE a tetromino at an anchor, or INIT the grid.
// Optional GRID_WRITER_INIT_EN enables the full-grid INIT sweep; otherwise INIT completes immediately.
module grid_piece_writer #(
  parameter int GRID_COLS = 12,
  parameter int GRID_ROWS = 22,
  // wide enough to reach the last cell, GRID_COLS*GRID_ROWS-1
  parameter int ADDR_W    = $clog2(GRID_COLS * GRID_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_piece,
  input  logic [1:0]        cmd_rot,
  input  logic [3:0]        cmd_col,
  input  logic [4:0]        cmd_row,
  output logic [ADDR_W-1:0] grid_addr,
  input  logic [7:0]        grid_rdata,
  output logic [7:0]        grid_wdata,
  output logic              grid_we,
  output logic              done,
  output logic              collision
);

  localparam logic [1:0] OP_CHECK = 2'd0;
  localparam logic [1:0] OP_PLACE = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_INIT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CMP,
    ST_WRITE,
    ST_DONE
`ifdef GRID_WRITER_INIT_EN
    , ST_INIT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        piece_q, piece_d;
  logic [1:0]        rot_q, rot_d;
  logic [3:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic              cur_oor_q, cur_oor_d;
  logic              prev_oor_q, prev_oor_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] grid_addr_q, grid_addr_d;
  logic [7:0]        grid_wdata_q, grid_wdata_d;
  logic              grid_we_q, grid_we_d;
  logic              done_q, done_d;
  logic              collision_q, collision_d;
`ifdef GRID_WRITER_INIT_EN
  logic [3:0]        init_col_q, init_col_d;
  logic [4:0]        init_row_q, init_row_d;
  logic [3:0]        nxt_col;
  logic [4:0]        nxt_row;
`endif

  logic [2:0]        g_piece;
  logic [1:0]        g_rot;
  logic [3:0]        g_col;
  logic [4:0]        g_row;
  logic [1:0]        g_k;
  logic              g_oor;
  logic [ADDR_W-1:0] g_addr;
  logic              hit;

  // Shape nibble k sits at bits [4k+3:4k] as {dx,dy}; rotation applied step by step.
  function automatic logic [ADDR_W:0] cell_pos(input logic [2:0] piece, input logic [1:0] rot,
                                               input logic [3:0] col, input logic [4:0] row,
                                               input logic [1:0] k);
    logic [15:0]       shape;
    logic [1:0]        x, y, t;
    logic [4:0]        c;
    logic [5:0]        r;
    logic [10:0]       lin;
    logic              oor;
    logic [ADDR_W-1:0] a;
    case (piece)
      3'd1:    shape = 16'hD951;
      3'd2:    shape = 16'h9584;
      3'd3:    shape = 16'h9514;
      3'd4:    shape = 16'h5184;
      3'd5:    shape = 16'h9540;
      3'd6:    shape = 16'h9510;
      3'd7:    shape = 16'h9518;
      default: shape = 16'h0000;
    endcase
    {x, y} = shape[{k, 2'b00} +: 4];
    for (int i = 0; i < 3; i++) begin
      if (i < int'(rot) && piece != 3'd2) begin
        t = x;
        x = (piece == 3'd1) ? 2'd3 - y : 2'd2 - y;
        y = t;
      end
    end
    c   = {1'b0, col} + {3'b000, x};
    r   = {1'b0, row} + {4'b0000, y};
    oor = (c >= 5'(GRID_COLS)) || (r >= 6'(GRID_ROWS));
    lin = 11'(r) * 11'(GRID_COLS) + 11'(c);
    a   = oor ? '0 : lin[ADDR_W-1:0];
    return {oor, a};
  endfunction

  always_comb begin
    if (state_q == ST_IDLE) begin
      g_piece = cmd_piece;
      g_rot   = cmd_rot;
      g_col   = cmd_col;
      g_row   = cmd_row;
      g_k     = 2'd0;
    end else begin
      g_piece = piece_q;
      g_rot   = rot_q;
      g_col   = col_q;
      g_row   = row_q;
      g_k     = (state_q == ST_CMP) ? 2'd0 : k_q + 2'd1;
    end
    {g_oor, g_addr} = cell_pos(g_piece, g_rot, g_col, g_row, g_k);

    // Read data belongs to the cell issued one cycle earlier; OOR cells read address 0, so mask them.
    hit = ((state_q == ST_READ && k_q != 2'd0) || state_q == ST_CMP) &&
          !prev_oor_q && (grid_rdata[3:0] != 4'd0);

    state_d      = state_q;
    k_d          = k_q;
    op_d         = op_q;
    piece_d      = piece_q;
    rot_d        = rot_q;
    col_d        = col_q;
    row_d        = row_q;
    cur_oor_d    = cur_oor_q;
    prev_oor_d   = cur_oor_q;
    cmd_ready_d  = cmd_ready_q;
    grid_addr_d  = grid_addr_q;
    grid_wdata_d = grid_wdata_q;
    grid_we_d    = 1'b0;
    done_d       = 1'b0;
    collision_d  = collision_q;
`ifdef GRID_WRITER_INIT_EN
    init_col_d   = init_col_q;
    init_row_d   = init_row_q;
    nxt_col      = (init_col_q == 4'(GRID_COLS - 1)) ? 4'd0 : init_col_q + 4'd1;
    nxt_row      = (init_col_q == 4'(GRID_COLS - 1)) ? init_row_q + 5'd1 : init_row_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          piece_d     = cmd_piece;
          rot_d       = cmd_rot;
          col_d       = cmd_col;
          row_d       = cmd_row;
          k_d         = 2'd0;
          cmd_ready_d = 1'b0;
          collision_d = 1'b0;
          case (cmd_op)
            OP_CHECK, OP_PLACE: begin
              if (cmd_op == OP_PLACE && cmd_piece == 3'd0) begin
                state_d     = ST_DONE;
                done_d      = 1'b1;
                collision_d = 1'b1;
              end else begin
                state_d     = ST_READ;
                grid_addr_d = g_addr;
                cur_oor_d   = g_oor;
                collision_d = g_oor;
              end
            end
            OP_ERASE: begin
              state_d      = ST_WRITE;
              grid_addr_d  = g_addr;
              grid_we_d    = !g_oor;
              grid_wdata_d = 8'h00;
            end
            OP_INIT: begin
`ifdef GRID_WRITER_INIT_EN
              state_d      = ST_INIT;
              init_col_d   = 4'd0;
              init_row_d   = 5'd0;
              grid_addr_d  = '0;
              grid_we_d    = 1'b1;
              grid_wdata_d = 8'h08;
`else
              state_d = ST_DONE;
              done_d  = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_READ: begin
        collision_d = collision_q | hit;
        if (k_q == 2'd3) begin
          state_d = ST_CMP;
        end else begin
          k_d         = k_q + 2'd1;
          grid_addr_d = g_addr;
          cur_oor_d   = g_oor;
          collision_d = collision_q | hit | g_oor;
        end
      end
      ST_CMP: begin
        collision_d = collision_q | hit;
        if (op_q == OP_PLACE && !(collision_q | hit)) begin
          state_d      = ST_WRITE;
          k_d          = 2'd0;
          grid_addr_d  = g_addr;
          grid_we_d    = !g_oor;
          grid_wdata_d = {5'b00000, piece_q};
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (k_q == 2'd3) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          k_d         = k_q + 2'd1;
          grid_addr_d = g_addr;
          grid_we_d   = !g_oor;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
`ifdef GRID_WRITER_INIT_EN
      ST_INIT: begin
        if (grid_addr_q == ADDR_W'(GRID_COLS * GRID_ROWS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          init_col_d   = nxt_col;
          init_row_d   = nxt_row;
          grid_addr_d  = grid_addr_q + 1'b1;
          grid_we_d    = 1'b1;
          grid_wdata_d = (nxt_col == 4'd0 || nxt_col == 4'(GRID_COLS - 1) ||
                          nxt_row == 5'(GRID_ROWS - 1)) ? 8'h08 : 8'h00;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      op_q         <= OP_CHECK;
      piece_q      <= 3'd0;
      rot_q        <= 2'd0;
      col_q        <= 4'd0;
      row_q        <= 5'd0;
      cur_oor_q    <= 1'b0;
      prev_oor_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      grid_addr_q  <= '0;
      grid_wdata_q <= 8'h00;
      grid_we_q    <= 1'b0;
      done_q       <= 1'b0;
      collision_q  <= 1'b0;
`ifdef GRID_WRITER_INIT_EN
      init_col_q   <= 4'd0;
      init_row_q   <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      op_q         <= op_d;
      piece_q      <= piece_d;
      rot_q        <= rot_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cur_oor_q    <= cur_oor_d;
      prev_oor_q   <= prev_oor_d;
      cmd_ready_q  <= cmd_ready_d;
      grid_addr_q  <= grid_addr_d;
      grid_wdata_q <= grid_wdata_d;
      grid_we_q    <= grid_we_d;
      done_q       <= done_d;
      collision_q  <= collision_d;
`ifdef GRID_WRITER_INIT_EN
      init_col_q   <= init_col_d;
      init_row_q   <= init_row_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign grid_addr  = grid_addr_q;
  assign grid_wdata = grid_wdata_q;
  // reset kills a pending write in the very cycle it is raised
  assign grid_we    = grid_we_q & ~reset;
  assign done       = done_q;
  assign collision  = collision_q;

endmodule
